bit_update_scheduler: RTL and testbench

BIT_UPDATE_SCHEDULER -- requirements
Module: bit_update_scheduler

---
 rtl/ldpc_pkg.sv | 27 ++
 rtl/bit_update_scheduler.sv | 169 ++++++++++++++++
 tb/tb_bit_update_scheduler.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder constants and the bit-update scheduler state encoding.
package ldpc_pkg;

   localparam int unsigned WIDTH_LLR      = 6;
   localparam int unsigned MAX_BLOCK_SIZE = 64;
   localparam int unsigned WIDTH_BLOCK    = $clog2(MAX_BLOCK_SIZE);
   localparam int unsigned MAX_EDGES      = 256;
   localparam int unsigned WIDTH_EDGE     = $clog2(MAX_EDGES) + 1;
   localparam int unsigned WIDTH_ITER     = 5;
   localparam int unsigned NUM_STATES     = 9;

   // Padding bit index; the engine discards adds aimed at it.
   localparam logic [WIDTH_BLOCK-1:0] DUMMY_INDEX = '1;

   typedef enum logic [NUM_STATES-1:0] {
      S_IDLE      = 9'b0_0000_0001,
      S_WAIT_MSG  = 9'b0_0000_0010,
      S_ISSUE     = 9'b0_0000_0100,
      S_GUARD     = 9'b0_0000_1000,
      S_WAIT_BU   = 9'b0_0001_0000,
      S_SWAP      = 9'b0_0010_0000,
      S_SWAP_WAIT = 9'b0_0100_0000,
      S_CHECK     = 9'b0_1000_0000,
      S_DONE      = 9'b1_0000_0000
   } state_t;

endpackage

// File: rtl/bit_update_scheduler.sv
// Sequences check-to-bit messages into the bit-update engine, one add at a time,
// with a memory swap and convergence check at the end of every iteration.
module bit_update_scheduler #(
   parameter int unsigned WIDTH_LLR      = ldpc_pkg::WIDTH_LLR,
   parameter int unsigned MAX_BLOCK_SIZE = ldpc_pkg::MAX_BLOCK_SIZE,
   parameter int unsigned MAX_EDGES      = ldpc_pkg::MAX_EDGES,
   parameter int unsigned WIDTH_ITER     = ldpc_pkg::WIDTH_ITER
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic                              abort,
   input  logic [$clog2(MAX_EDGES):0]        num_edges,
   input  logic [WIDTH_ITER-1:0]             max_iter,
   input  logic                              msg_valid,
   output logic                              msg_ready,
   input  logic [$clog2(MAX_BLOCK_SIZE)-1:0] msg_index,
   input  logic [WIDTH_LLR-1:0]              msg_llr,
   input  logic                              msg_sign,
   input  logic                              msg_last,
   input  logic                              syndrome_ok,
   input  logic                              bu_ready,
   output logic                              bu_add,
   output logic                              bu_change_memory,
   output logic [$clog2(MAX_BLOCK_SIZE)-1:0] bu_index,
   output logic [WIDTH_LLR-1:0]              bu_llr,
   output logic                              bu_sign,
   output logic                              busy,
   output logic                              done,
   output logic                              converged,
   output logic [WIDTH_ITER-1:0]             iter_count,
   output logic                              err_edge
);
   import ldpc_pkg::*;

   localparam int unsigned IDX_W  = $clog2(MAX_BLOCK_SIZE);
   localparam int unsigned EDGE_W = $clog2(MAX_EDGES) + 1;

   state_t                r_state;
   state_t                w_state_next;
   logic                  r_abort_pend;
   logic                  r_swap_guard;
   logic [IDX_W-1:0]      r_index;
   logic [WIDTH_LLR-1:0]  r_llr;
   logic                  r_sign;
   logic                  r_last;
   logic [EDGE_W-1:0]     r_edge_cnt;
   logic [WIDTH_ITER-1:0] r_iter;
   logic                  r_err_edge;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_converged;
   logic                  r_bu_add;
   logic                  r_bu_change;

   logic w_accept;
   logic w_abort_any;
   logic w_start_ok;
   logic w_inflight;

   assign msg_ready   = (r_state == S_WAIT_MSG) && bu_ready;
   assign w_accept    = msg_valid && msg_ready;
   assign w_abort_any = abort || r_abort_pend;
   assign w_start_ok  = (r_state == S_IDLE) && start && !abort;
   assign w_inflight  = r_state inside {S_ISSUE, S_GUARD, S_WAIT_BU, S_SWAP, S_SWAP_WAIT};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // Next state; a pending abort only takes effect once the engine is ready again.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:      if (w_start_ok) w_state_next = S_WAIT_MSG;
         S_WAIT_MSG: begin
            if (abort)         w_state_next = S_IDLE;
            else if (w_accept) w_state_next = S_ISSUE;
         end
         S_ISSUE:     w_state_next = S_GUARD;
         S_GUARD:     w_state_next = S_WAIT_BU;
         S_WAIT_BU: begin
            if (bu_ready) begin
               if (w_abort_any) w_state_next = S_IDLE;
               else if (r_last) w_state_next = S_SWAP;
               else             w_state_next = S_WAIT_MSG;
            end
         end
         S_SWAP:      w_state_next = S_SWAP_WAIT;
         S_SWAP_WAIT: begin
            if (!r_swap_guard && bu_ready)
               w_state_next = w_abort_any ? S_IDLE : S_CHECK;
         end
         S_CHECK: begin
            if (abort)                                   w_state_next = S_IDLE;
            else if (syndrome_ok || (r_iter >= max_iter)) w_state_next = S_DONE;
            else                                         w_state_next = S_WAIT_MSG;
         end
         S_DONE:      w_state_next = S_IDLE;
         default:     w_state_next = S_IDLE;
      endcase
   end

   // Registered outputs and datapath, decoded from the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_abort_pend <= 1'b0;
         r_swap_guard <= 1'b0;
         r_index      <= '0;
         r_llr        <= '0;
         r_sign       <= 1'b0;
         r_last       <= 1'b0;
         r_edge_cnt   <= '0;
         r_iter       <= '0;
         r_err_edge   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_converged  <= 1'b0;
         r_bu_add     <= 1'b0;
         r_bu_change  <= 1'b0;
      end else begin
         r_bu_add     <= (w_state_next == S_ISSUE);
         r_bu_change  <= (w_state_next == S_SWAP);
         r_done       <= (w_state_next == S_DONE);
         r_busy       <= (w_state_next != S_IDLE);
         r_swap_guard <= (r_state == S_SWAP);

         if (w_start_ok) begin
            r_iter      <= '0;
            r_edge_cnt  <= '0;
            r_err_edge  <= 1'b0;
            r_converged <= 1'b0;
         end

         if (w_accept) begin
            r_index    <= msg_index;
            r_llr      <= msg_llr;
            r_sign     <= msg_sign;
            r_last     <= msg_last;
            r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
         end

         if (r_state == S_SWAP) begin
            if (r_iter != '1)              r_iter     <= r_iter + WIDTH_ITER'(1);
            if (r_edge_cnt != num_edges)   r_err_edge <= 1'b1;
            r_edge_cnt <= '0;
         end

         if ((r_state == S_CHECK) && (w_state_next == S_DONE))
            r_converged <= syndrome_ok;

         if (abort && w_inflight)       r_abort_pend <= 1'b1;
         if (w_state_next == S_IDLE)    r_abort_pend <= 1'b0;
      end
   end

   assign bu_add           = r_bu_add;
   assign bu_change_memory = r_bu_change;
   assign bu_index         = r_index;
   assign bu_llr           = r_llr;
   assign bu_sign          = r_sign;
   assign busy             = r_busy;
   assign done             = r_done;
   assign converged        = r_converged;
   assign iter_count       = r_iter;
   assign err_edge         = r_err_edge;

endmodule

// File: tb/tb_bit_update_scheduler.sv
// Directed self-checking bench for bit_update_scheduler with a simple engine ready model.
module tb_bit_update_scheduler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [8:0] num_edges = 9'd4;
   logic [4:0] max_iter = 5'd3;
   logic       msg_valid;
   logic       msg_ready;
   logic [5:0] msg_index;
   logic [5:0] msg_llr;
   logic       msg_sign;
   logic       msg_last;
   logic       syndrome_ok = 1'b0;
   logic       bu_ready = 1'b1;
   logic       bu_add;
   logic       bu_change_memory;
   logic [5:0] bu_index;
   logic [5:0] bu_llr;
   logic       bu_sign;
   logic       busy;
   logic       done;
   logic       converged;
   logic [4:0] iter_count;
   logic       err_edge;

   int n_cmp = 0;
   int n_err = 0;

   logic [5:0] m_idx  [32];
   logic [5:0] m_llr  [32];
   logic       m_sign [32];
   logic       m_last [32];
   int n_msgs = 0;
   int ptr = 0;

   int  cyc = 0, eng_cnt = 0, last_add = -1, min_gap = 99;
   int  add_cnt = 0, swap_cnt = 0, done_cnt = 0;
   bit  hold_low = 1'b0;

   bit_update_scheduler dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .num_edges(num_edges), .max_iter(max_iter),
      .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_index(msg_index),
      .msg_llr(msg_llr), .msg_sign(msg_sign), .msg_last(msg_last),
      .syndrome_ok(syndrome_ok), .bu_ready(bu_ready), .bu_add(bu_add),
      .bu_change_memory(bu_change_memory), .bu_index(bu_index), .bu_llr(bu_llr),
      .bu_sign(bu_sign), .busy(busy), .done(done), .converged(converged),
      .iter_count(iter_count), .err_edge(err_edge)
   );

   always #5 clk = ~clk;

   assign msg_valid = (ptr < n_msgs);
   assign msg_index = m_idx[ptr[4:0]];
   assign msg_llr   = m_llr[ptr[4:0]];
   assign msg_sign  = m_sign[ptr[4:0]];
   assign msg_last  = msg_valid && m_last[ptr[4:0]];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic kick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Fill the source with the repeating pattern; msg_last every 'period' messages.
   task automatic load(input int n, input int period);
      logic [5:0] s_idx [4];
      logic [5:0] s_llr [4];
      logic       s_sgn [4];
      s_idx = '{6'd5, 6'd9, 6'd63, 6'd0};
      s_llr = '{6'd12, 6'd63, 6'd1, 6'd40};
      s_sgn = '{1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < n; i++) begin
         m_idx[i]  = s_idx[i % 4];
         m_llr[i]  = s_llr[i % 4];
         m_sign[i] = s_sgn[i % 4];
         m_last[i] = ((i % period) == period - 1);
      end
      ptr = 0;
      n_msgs = n;
      last_add = -1;
      min_gap = 99;
   endtask

   task automatic wait_done(input string tag);
      int k;
      k = 0;
      while (done !== 1'b1 && k < 600) begin
         tick();
         k++;
      end
      chk({tag, "_done"}, 32'(done), 1);
   endtask

   // Engine model and command monitor: ready drops for two cycles after each command.
   always @(negedge clk) begin
      cyc++;
      if (bu_add || bu_change_memory) begin
         chk("cmd_while_ready", 32'(bu_ready), 1);
         chk("cmd_exclusive", 32'(bu_add & bu_change_memory), 0);
      end
      if (bu_add) begin
         add_cnt++;
         if (ptr < n_msgs) begin
            chk("bu_index", 32'(bu_index), 32'(m_idx[ptr[4:0]]));
            chk("bu_llr",   32'(bu_llr),   32'(m_llr[ptr[4:0]]));
            chk("bu_sign",  32'(bu_sign),  32'(m_sign[ptr[4:0]]));
         end
         if (last_add >= 0 && (cyc - last_add) < min_gap) min_gap = cyc - last_add;
         last_add = cyc;
         ptr++;
      end
      if (bu_change_memory) swap_cnt++;
      if (done) done_cnt++;
      if (eng_cnt > 0) eng_cnt--;
      if (bu_add || bu_change_memory) eng_cnt = 2;
      bu_ready = !hold_low && (eng_cnt == 0);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int a0, s0, d0, k;

      repeat (3) tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_iter", 32'(iter_count), 0);
      chk("rst_err",  32'(err_edge), 0);
      chk("rst_add",  32'(bu_add), 0);
      chk("rst_swap", 32'(bu_change_memory), 0);
      chk("rst_idx",  32'(bu_index), 0);
      chk("rst_conv", 32'(converged), 0);
      chk("rst_mrdy", 32'(msg_ready), 0);
      rst_n = 1'b1;
      tick();

      // Three full iterations, never converging; a stray start mid-run must be ignored.
      syndrome_ok = 1'b0; max_iter = 5'd3; num_edges = 9'd4; load(12, 4);
      a0 = add_cnt; s0 = swap_cnt; d0 = done_cnt;
      kick();
      chk("t1_busy", 32'(busy), 1);
      repeat (10) tick();
      kick();
      wait_done("t1");
      chk("t1_conv", 32'(converged), 0);
      chk("t1_iter", 32'(iter_count), 3);
      chk("t1_err",  32'(err_edge), 0);
      tick();
      chk("t1_busy_after", 32'(busy), 0);
      chk("t1_adds",  32'(add_cnt - a0), 12);
      chk("t1_swaps", 32'(swap_cnt - s0), 3);
      chk("t1_dones", 32'(done_cnt - d0), 1);
      chk("t1_min_gap", 32'(min_gap), 4);
      repeat (4) tick();
      chk("t1_iter_hold", 32'(iter_count), 3);

      // Converges after the first iteration.
      syndrome_ok = 1'b1; max_iter = 5'd10; load(4, 4);
      a0 = add_cnt; s0 = swap_cnt;
      kick();
      wait_done("t2");
      chk("t2_conv", 32'(converged), 1);
      chk("t2_iter", 32'(iter_count), 1);
      tick();
      chk("t2_adds",  32'(add_cnt - a0), 4);
      chk("t2_swaps", 32'(swap_cnt - s0), 1);
      repeat (3) tick();
      chk("t2_conv_hold", 32'(converged), 1);

      // Short iteration: msg_last on the third message while four are expected.
      syndrome_ok = 1'b0; max_iter = 5'd1; num_edges = 9'd4; load(3, 3);
      kick();
      wait_done("t3");
      chk("t3_err",  32'(err_edge), 1);
      chk("t3_conv", 32'(converged), 0);
      chk("t3_iter", 32'(iter_count), 1);
      repeat (5) tick();
      chk("t3_err_sticky", 32'(err_edge), 1);

      // Single-edge iteration; the new start clears the sticky error.
      num_edges = 9'd1; load(1, 1);
      a0 = add_cnt;
      kick();
      chk("t4_err_cleared", 32'(err_edge), 0);
      wait_done("t4");
      chk("t4_err",  32'(err_edge), 0);
      chk("t4_iter", 32'(iter_count), 1);
      tick();
      chk("t4_adds", 32'(add_cnt - a0), 1);

      // Abort while waiting for the engine after an add.
      num_edges = 9'd4; max_iter = 5'd3; load(4, 4);
      a0 = add_cnt; s0 = swap_cnt; d0 = done_cnt;
      kick();
      k = 0;
      while (bu_add !== 1'b1 && k < 50) begin tick(); k++; end
      chk("t5_add_seen", 32'(bu_add), 1);
      hold_low = 1'b1;
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      repeat (2) tick();
      chk("t5_busy_pending", 32'(busy), 1);
      hold_low = 1'b0;
      tick();
      chk("t5_busy_off", 32'(busy), 0);
      repeat (5) tick();
      chk("t5_no_done", 32'(done_cnt - d0), 0);
      chk("t5_adds",    32'(add_cnt - a0), 1);
      chk("t5_swaps",   32'(swap_cnt - s0), 0);
      chk("t5_conv",    32'(converged), 0);

      syndrome_ok = 1'b1; max_iter = 5'd10; load(4, 4);
      kick();
      wait_done("t5_rerun");
      chk("t5_rerun_conv", 32'(converged), 1);
      chk("t5_rerun_iter", 32'(iter_count), 1);
      tick();

      // start and abort together in IDLE: abort wins.
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("t6_busy", 32'(busy), 0);
      tick();
      chk("t6_busy2", 32'(busy), 0);

      // Reset asserted during SWAP_WAIT.
      syndrome_ok = 1'b0; max_iter = 5'd3; load(4, 4);
      kick();
      k = 0;
      while (bu_change_memory !== 1'b1 && k < 100) begin tick(); k++; end
      chk("t7_swap_seen", 32'(bu_change_memory), 1);
      tick();
      rst_n = 1'b0;
      #1;
      chk("t7_busy", 32'(busy), 0);
      chk("t7_iter", 32'(iter_count), 0);
      chk("t7_err",  32'(err_edge), 0);
      chk("t7_done", 32'(done), 0);
      chk("t7_add",  32'(bu_add), 0);
      chk("t7_idx",  32'(bu_index), 0);
      a0 = add_cnt; s0 = swap_cnt; d0 = done_cnt;
      tick();
      rst_n = 1'b1;
      repeat (30) tick();
      chk("t7_no_done",  32'(done_cnt - d0), 0);
      chk("t7_no_add",   32'(add_cnt - a0), 0);
      chk("t7_no_swap",  32'(swap_cnt - s0), 0);
      chk("t7_busy_end", 32'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
